ifetch: RTL



---
 rtl/ifetch.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, keeps one icache request in flight and queues
// {pc, instruction} pairs toward decode. Define IFETCH_BYPASS_EN to forward into an empty queue.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_req_addr,
    output logic        o_req_valid,
    input  logic [31:0] i_resp_data,
    input  logic        i_resp_valid,
    input  logic        i_resp_ready,
    output logic        o_inst_valid,
    output logic [31:0] o_inst_data,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);
    localparam int unsigned PtrW = $clog2(FQ_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(FQ_DEPTH);

    typedef enum logic [0:0] {StReq, StWait} state_e;

    state_e          r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_req_pc;
    logic            r_kill;

    logic [31:0]     r_mem_data [FQ_DEPTH];
    logic [31:0]     r_mem_pc   [FQ_DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic [31:0]     r_head_data;
    logic [31:0]     r_head_pc;

    logic            w_accept;
    logic            w_resp_ok;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic            w_fq_valid;
    logic [CntW-1:0] w_count_nxt;
    logic [PtrW-1:0] w_rd_ptr_nxt;
    logic [PtrW-1:0] w_wr_ptr_nxt;
    logic            w_head_from_push;

    // Redirect suppresses issue combinationally so an accept never races a PC change.
    assign o_req_valid = !i_rst && (r_state == StReq) && (r_count < DepthC) && !i_redirect_valid;
    assign o_req_addr  = r_pc;
    assign w_accept    = o_req_valid && i_resp_ready;

    assign w_resp_ok   = (r_state == StWait) && i_resp_valid && !r_kill && !i_redirect_valid;
    assign w_fq_valid  = (r_count != '0);

`ifdef IFETCH_BYPASS_EN
    assign w_bypass = w_resp_ok && !w_fq_valid && i_inst_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push       = w_resp_ok && !w_bypass;
    assign w_pop        = w_fq_valid && i_inst_ready;
    assign w_count_nxt  = r_count + CntW'(w_push) - CntW'(w_pop);
    assign w_rd_ptr_nxt = r_rd_ptr + PtrW'(w_pop);
    assign w_wr_ptr_nxt = r_wr_ptr + PtrW'(w_push);
    // The slot being written becomes the head when the queue drains onto it.
    assign w_head_from_push = w_push && (r_wr_ptr == w_rd_ptr_nxt);

    assign o_inst_valid = w_fq_valid || w_bypass;
    assign o_inst_data  = w_bypass ? i_resp_data : r_head_data;
    assign o_inst_pc    = w_bypass ? r_req_pc    : r_head_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StReq;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_kill   <= 1'b0;
        end else begin
            case (r_state)
                StReq: begin
                    if (w_accept) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= StWait;
                    end
                end
                StWait: begin
                    if (i_resp_valid) begin
                        r_kill  <= 1'b0;
                        r_state <= StReq;
                    end else if (i_redirect_valid) begin
                        r_kill  <= 1'b1;
                    end
                end
                default: r_state <= StReq;
            endcase
            if (i_redirect_valid) begin
                r_pc <= {i_redirect_pc[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem_data[r_wr_ptr] <= i_resp_data;
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    // Head registers hold their last value whenever the queue is (or becomes) empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head_data <= 32'h0;
            r_head_pc   <= 32'h0;
        end else if (i_redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_count_nxt != '0) begin
                if (w_head_from_push) begin
                    r_head_data <= i_resp_data;
                    r_head_pc   <= r_req_pc;
                end else begin
                    r_head_data <= r_mem_data[w_rd_ptr_nxt];
                    r_head_pc   <= r_mem_pc[w_rd_ptr_nxt];
                end
            end
        end
    end

endmodule
